// File: rtl/raw10_packet_ctrl.sv
// CSI-2 packet sequencer for the RAW10 decoder: parses headers, tracks frames,
// strips headers/CRC and gates long-packet payload with frame_active.
module raw10_packet_ctrl #(
    parameter logic [1:0]  VC_SEL   = 2'd0,
    parameter logic [5:0]  DT_RAW10 = 6'h2B,
    parameter logic [15:0] MAX_WC   = 16'd8000
) (
    input  logic        rxbyteclkhs,
    input  logic        reset_n,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic [15:0] payload_data,
    output logic        frame_active,
    output logic        frame_valid,
    output logic [15:0] line_count,
    output logic [15:0] frame_count,
    output logic        pkt_err,
    output logic [2:0]  err_code
);

    typedef enum logic [1:0] {
        IDLE,
        HDR2,
        PAYLOAD,
        CRC
    } state_e;

    state_e      state_q;
    logic [7:0]  di_q;
    logic [7:0]  wc_lo_q;
    logic [15:0] rem_q;
    logic        fwd_q;

    logic [15:0] wc;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic        id_match;
    logic        wc_ok;
    logic        abort;

    assign wc       = {data_in[15:8], wc_lo_q};
    assign vc       = di_q[7:6];
    assign dt       = di_q[5:0];
    assign id_match = (vc == VC_SEL) && (dt == DT_RAW10);
    assign wc_ok    = ((wc % 16'd10) == 16'd0);
    // A gap in data_valid anywhere inside a packet kills the packet.
    assign abort    = !data_valid && (state_q != IDLE);

    always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            di_q         <= 8'd0;
            wc_lo_q      <= 8'd0;
            rem_q        <= 16'd0;
            fwd_q        <= 1'b0;
            payload_data <= 16'd0;
            frame_active <= 1'b0;
            frame_valid  <= 1'b0;
            line_count   <= 16'd0;
            frame_count  <= 16'd0;
            pkt_err      <= 1'b0;
            err_code     <= 3'd0;
        end else begin
            payload_data <= data_in;
            frame_active <= 1'b0;
            pkt_err      <= 1'b0;
            if (abort) begin
                pkt_err  <= 1'b1;
                err_code <= 3'd3;
                state_q  <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (data_valid) begin
                            di_q    <= data_in[15:8];
                            wc_lo_q <= data_in[7:0];
                            state_q <= HDR2;
                        end
                    end
                    HDR2: begin
                        if (dt <= 6'h0F) begin
                            state_q <= IDLE;
                            if (vc == VC_SEL && dt == 6'h00) begin
                                frame_valid <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                                line_count  <= 16'd0;
                            end else if (vc == VC_SEL && dt == 6'h01) begin
                                frame_valid <= 1'b0;
                            end
                        end else if (wc > MAX_WC) begin
                            pkt_err  <= 1'b1;
                            err_code <= 3'd2;
                            state_q  <= IDLE;
                        end else if (wc == 16'd0) begin
                            fwd_q   <= 1'b0;
                            state_q <= CRC;
                        end else begin
                            rem_q   <= wc;
                            fwd_q   <= id_match && wc_ok && frame_valid;
                            state_q <= PAYLOAD;
                            if (id_match && !wc_ok) begin
                                pkt_err  <= 1'b1;
                                err_code <= 3'd1;
                            end else if (id_match && !frame_valid) begin
                                pkt_err  <= 1'b1;
                                err_code <= 3'd4;
                            end
                        end
                    end
                    PAYLOAD: begin
                        frame_active <= fwd_q;
                        // Odd WC: the trailing low byte is dropped.
                        if (rem_q <= 16'd2) begin
                            rem_q   <= 16'd0;
                            state_q <= CRC;
                        end else begin
                            rem_q <= rem_q - 16'd2;
                        end
                    end
                    CRC: begin
                        if (fwd_q) begin
                            line_count <= line_count + 16'd1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/raw10_packet_ctrl.md
Name: raw10_packet_ctrl

Overview:
- Sequences the RAW10 decoder from the 16-bit aligned byte stream of the CSI-2 receiver.
- Parses packet headers and tracks frame state from Frame Start / Frame End short packets.
- Forwards RAW10 long-packet payload to raw10_decoder with its frame_active/frame_valid gating, and strips headers and CRC footers.
- Counts lines and frames, and flags malformed packets.

Parameters:
- VC_SEL, 2'd0, virtual channel accepted; all others are skipped.
- DT_RAW10, 6'h2B, data type forwarded to the decoder.
- MAX_WC, 16'd8000, largest legal long-packet word count in bytes.

Ports:
- rxbyteclkhs  input  1  byte clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data_in  input  16  two bytes per cycle; [15:8] is the earlier byte.
- data_valid  input  1  data_in carries packet bytes this cycle.
- payload_data  output  16  registered payload, connects to decoder data_in.
- frame_active  output  1  high on cycles where payload_data is a RAW10 payload word.
- frame_valid  output  1  high between accepted Frame Start and Frame End.
- line_count  output  16  RAW10 lines forwarded in the current frame.
- frame_count  output  16  Frame Start packets accepted since reset (wraps).
- pkt_err  output  1  one-cycle error pulse.
- err_code  output  3  cause of the last error; held until the next error.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0.
- Header layout: cycle H0 carries DI=data_in[15:8] and WC[7:0]=data_in[7:0]; cycle H1 carries WC[15:8]=data_in[15:8] and ECC=data_in[7:0].
- DI[7:6] is the VC; DI[5:0] is the DT. ECC is not checked.
- IDLE: when data_valid=1, capture DI and WC_lo, then go to HDR2. Otherwise stay in IDLE.
- HDR2 (data_valid=1 required): form WC and classify the packet.
- Short packet (DT<=0x0F): WC field ignored; return to IDLE.
  - If VC matches and DT=0x00: frame_valid<=1, frame_count+1, line_count<=0.
  - If VC matches and DT=0x01: frame_valid<=0.
  - Any other DT: no action.
- Long packet, WC>MAX_WC: pkt_err, err_code=2, return to IDLE.
- Long packet, WC=0: go to CRC.
- Other long packets: go to PAYLOAD, with rem<=WC and fwd computed as below.
- fwd=1 only if all of: VC==VC_SEL, DT==DT_RAW10, WC%10==0, frame_valid=1.
  - VC and DT match but WC%10!=0: pkt_err, err_code=1.
  - VC and DT match but frame_valid=0: pkt_err, err_code=4.
  - In both error cases the packet is still traversed with fwd=0.
- PAYLOAD: each data_valid cycle rem-=2. If rem==1, rem<=0 (odd WC; the last low byte is ignored). When rem reaches 0, go to CRC.
- CRC: consume one data_valid cycle (CRC is not checked), return to IDLE. If fwd=1, line_count+1 on this cycle.
- Decoder interface: payload_data<=data_in and frame_active<=(state==PAYLOAD & fwd & data_valid), registered. This gives 1-cycle latency and exactly WC/2 consecutive active cycles per forwarded packet.
- frame_active drops between packets so the decoder re-aligns to its state 0 on every line.
- data_valid=0 in HDR2, PAYLOAD or CRC: abort. pkt_err, err_code=3, frame_active<=0, return to IDLE. line_count is not incremented. frame_valid is unchanged.
- Event precedence: abort beats all other events. Simultaneous error cases report the lowest err_code.
- Counters wrap at 16'hFFFF without an error.
- Reset mid-packet: immediate return to IDLE; all outputs 0.

Test Plan:
- FS(VC0), RAW10 long packet with WC=10 (5 payload cycles), CRC, FE -> frame_valid rises the cycle after FS H1; frame_active high for exactly 5 cycles, 1 cycle after the payload; payload_data matches the input words; line_count=1; frame_count=1; frame_valid falls after FE; no pkt_err.
- Two back-to-back RAW10 packets with WC=20 -> 10 active cycles each with a gap of at least 3 cycles between them; line_count=2.
- RAW10 packet with WC=12 inside a frame -> pkt_err pulse, err_code=1, frame_active stays 0 for all 6 payload cycles, line_count unchanged, next packet parsed correctly.
- RAW10 packet on VC=1, and a DT=0x2A packet with WC=10 -> both skipped silently, frame_active=0, no error, the following header parsed correctly.
- data_valid low on the 3rd payload cycle of a WC=10 packet -> pkt_err, err_code=3, frame_active low next cycle, state=IDLE, line_count unchanged.
- reset_n asserted mid-payload -> all outputs 0 immediately. After release, FS + RAW10 WC=10 behaves as in the first scenario, with frame_count=1.
